// File: rtl/fft8_pkg.sv
// Shared constants, sample type and lane-packing helper for the 8-point FFT datapath.
package fft8_pkg;

  localparam int FFT_N      = 8;
  localparam int FFT_DATA_W = 32;
  localparam int FFT_IDX_W  = 3;

  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } cplx_t;

  // Bit offset of lane k inside a flat N*W lane bus; the output deserializer uses the same layout.
  function automatic int lane_off(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/fft8_frame_bank.sv
// One bank of N_PTS complex registers: indexed single-word write, all lanes read in parallel.
module fft8_frame_bank
  import fft8_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N_PTS  = FFT_N
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [FFT_IDX_W-1:0]       wr_idx,
  input  logic signed [DATA_W-1:0]   wr_real,
  input  logic signed [DATA_W-1:0]   wr_imag,
  output logic [N_PTS*DATA_W-1:0]    rd_real,
  output logic [N_PTS*DATA_W-1:0]    rd_imag
);

  logic signed [DATA_W-1:0] re_q [N_PTS];
  logic signed [DATA_W-1:0] im_q [N_PTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_PTS; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else if (wr_en) begin
      re_q[wr_idx] <= wr_real;
      im_q[wr_idx] <= wr_imag;
    end
  end

  always_comb begin
    rd_real = '0;
    rd_imag = '0;
    for (int k = 0; k < N_PTS; k++) begin
      rd_real[lane_off(k, DATA_W) +: DATA_W] = re_q[k];
      rd_imag[lane_off(k, DATA_W) +: DATA_W] = im_q[k];
    end
  end

endmodule

// File: rtl/fft8_input_framer.sv
// Ping-pong framer: collects 8 streamed complex samples per bank and presents full banks
// as parallel FFT lanes under a frame valid/ready handshake.
module fft8_input_framer
  import fft8_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N_PTS  = FFT_N,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [DATA_W-1:0]   s_real,
  input  logic signed [DATA_W-1:0]   s_imag,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [N_PTS*DATA_W-1:0]    frame_real,
  output logic [N_PTS*DATA_W-1:0]    frame_imag,
  output logic [FFT_IDX_W-1:0]       wr_idx,
  output logic [CNT_W-1:0]           frame_cnt
);

  localparam logic [FFT_IDX_W-1:0] LAST_IDX = FFT_IDX_W'(N_PTS - 1);

  logic [1:0]              bank_full;
  logic [1:0]              bank_full_d;
  logic                    wr_bank;
  logic                    rd_bank;
  logic                    accept;
  logic                    frame_done;
  logic                    handoff;
  logic [1:0]              bank_we;
  logic [N_PTS*DATA_W-1:0] bank_real [2];
  logic [N_PTS*DATA_W-1:0] bank_imag [2];

  // Handshake outputs depend on registers only, never on s_valid or frame_ready.
  assign s_ready     = !bank_full[wr_bank];
  assign frame_valid = bank_full[rd_bank];

  // flush takes priority over a coincident sample, which is dropped.
  assign accept     = s_valid && s_ready && !flush;
  assign frame_done = accept && (wr_idx == LAST_IDX);
  assign handoff    = frame_valid && frame_ready;

  assign bank_we[0] = accept && (wr_bank == 1'b0);
  assign bank_we[1] = accept && (wr_bank == 1'b1);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft8_frame_bank #(
      .DATA_W (DATA_W),
      .N_PTS  (N_PTS)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bank_we[b]),
      .wr_idx  (wr_idx),
      .wr_real (s_real),
      .wr_imag (s_imag),
      .rd_real (bank_real[b]),
      .rd_imag (bank_imag[b])
    );
  end

  assign frame_real = bank_real[rd_bank];
  assign frame_imag = bank_imag[rd_bank];

  // A completing write always targets the empty bank and a handoff the full one, so both
  // updates can be merged into the same edge without conflict.
  always_comb begin
    bank_full_d = bank_full;
    if (handoff)    bank_full_d[rd_bank] = 1'b0;
    if (frame_done) bank_full_d[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      frame_cnt <= '0;
    end else begin
      bank_full <= bank_full_d;
      if (frame_done) wr_bank <= ~wr_bank;
      if (handoff) begin
        rd_bank   <= ~rd_bank;
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (flush)           wr_idx <= '0;
      else if (frame_done) wr_idx <= '0;
      else if (accept)     wr_idx <= wr_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_fft8_input_framer.sv
// Directed bench for fft8_input_framer: streaming, backpressure, flush, async reset, overlap.
module tb_fft8_input_framer;

  localparam int DATA_W = 32;
  localparam int N_PTS  = 8;
  localparam int CNT_W  = 16;

  logic                    clk;
  logic                    rst_n;
  logic                    flush;
  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_W-1:0]       s_real;
  logic [DATA_W-1:0]       s_imag;
  logic                    frame_valid;
  logic                    frame_ready;
  logic [N_PTS*DATA_W-1:0] frame_real;
  logic [N_PTS*DATA_W-1:0] frame_imag;
  logic [2:0]              wr_idx;
  logic [CNT_W-1:0]        frame_cnt;

  int checks = 0;
  int errors = 0;
  int fr;

  fft8_input_framer #(
    .DATA_W (DATA_W),
    .N_PTS  (N_PTS),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_real      (s_real),
    .s_imag      (s_imag),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_real  (frame_real),
    .frame_imag  (frame_imag),
    .wr_idx      (wr_idx),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  function automatic logic [31:0] lane_re(input int k);
    return frame_real[k*DATA_W +: DATA_W];
  endfunction

  function automatic logic [31:0] lane_im(input int k);
    return frame_imag[k*DATA_W +: DATA_W];
  endfunction

  // Drive one sample for one cycle; returns at 1 time unit after the edge.
  task automatic send_one(input int re, input int im);
    s_valid = 1'b1;
    s_real  = 32'(re);
    s_imag  = 32'(im);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input int base_re, input int base_im_sign);
    for (int k = 0; k < N_PTS; k++) begin
      chk({tag, "_re"}, lane_re(k), 32'(base_re + k));
      if (base_im_sign != 0) chk({tag, "_im"}, lane_im(k), 32'(-(base_re + k)));
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    s_valid     = 1'b0;
    s_real      = '0;
    s_imag      = '0;
    frame_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_wr_idx", 32'(wr_idx), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_frame_zero", 32'(|{frame_real, frame_imag}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: re=1..8, im=-1..-8 with frame_ready=1
    frame_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_one(i + 1, -(i + 1));
      if (i == 6) chk("t1_valid_before_8th", 32'(frame_valid), 32'd0);
    end
    chk("t1_valid_after_8th", 32'(frame_valid), 32'd1);
    chk_frame("t1_lane", 1, 1);
    chk("t1_cnt_pending", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_valid_cleared", 32'(frame_valid), 32'd0);

    // Test 2: 24 back-to-back samples, frames handed off in order
    fr = 0;
    for (int i = 0; i < 24; i++) begin
      chk("t2_s_ready", 32'(s_ready), 32'd1);
      send_one(200 + i, -(200 + i));
      if (frame_valid) begin
        chk("t2_order_lane0", lane_re(0), 32'(200 + 8 * fr));
        chk("t2_order_lane7", lane_re(7), 32'(200 + 8 * fr + 7));
        fr++;
      end
    end
    @(posedge clk);
    #1;
    chk("t2_frames_seen", 32'(fr), 32'd3);
    chk("t2_cnt", 32'(frame_cnt), 32'd4);
    chk("t2_valid_cleared", 32'(frame_valid), 32'd0);

    // Test 3: backpressure with 20 samples offered
    frame_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("t3_s_ready", 32'(s_ready), 32'(i < 16));
      send_one(300 + i, 0);
    end
    chk("t3_wr_idx", 32'(wr_idx), 32'd0);
    chk("t3_s_ready_low", 32'(s_ready), 32'd0);
    chk("t3_valid", 32'(frame_valid), 32'd1);
    chk_frame("t3_f1", 300, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_hold_lane3", lane_re(3), 32'd303);
    chk("t3_hold_cnt", 32'(frame_cnt), 32'd4);
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    chk("t3_s_ready_back", 32'(s_ready), 32'd1);
    chk("t3_valid_f2", 32'(frame_valid), 32'd1);
    chk_frame("t3_f2", 308, 0);
    chk("t3_cnt_f1", 32'(frame_cnt), 32'd5);
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_cnt_f2", 32'(frame_cnt), 32'd6);
    chk("t3_drained", 32'(frame_valid), 32'd0);

    // Test 4: partial frame, flush (with a dropped coincident sample), new frame
    for (int i = 0; i < 5; i++) send_one(50 + i, 0);
    chk("t4_wr_idx_partial", 32'(wr_idx), 32'd5);
    flush = 1'b1;
    send_one(99, 0);
    flush = 1'b0;
    chk("t4_wr_idx_flushed", 32'(wr_idx), 32'd0);
    chk("t4_cnt_after_flush", 32'(frame_cnt), 32'd6);
    for (int i = 0; i < 8; i++) send_one(100 + i, -(100 + i));
    chk("t4_valid", 32'(frame_valid), 32'd1);
    chk_frame("t4_lane", 100, 1);
    @(posedge clk);
    #1;
    chk("t4_cnt", 32'(frame_cnt), 32'd7);

    // Test 5: asynchronous reset during 3rd sample of frame 2, frame 1 pending
    frame_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_one(400 + i, 0);
    send_one(410, 0);
    send_one(411, 0);
    chk("t5_pending", 32'(frame_valid), 32'd1);
    s_valid = 1'b1;
    s_real  = 32'd412;
    s_imag  = 32'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(frame_valid), 32'd0);
    chk("t5_rst_s_ready", 32'(s_ready), 32'd1);
    chk("t5_rst_wr_idx", 32'(wr_idx), 32'd0);
    chk("t5_rst_cnt", 32'(frame_cnt), 32'd0);
    chk("t5_rst_frame_zero", 32'(|{frame_real, frame_imag}), 32'd0);
    s_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_one(500 + i, -(500 + i));
    chk("t5_clean_valid", 32'(frame_valid), 32'd1);
    chk_frame("t5_clean", 500, 1);
    @(posedge clk);
    #1;
    chk("t5_cnt", 32'(frame_cnt), 32'd1);

    // Test 6: 8th sample of one bank coincides with handoff of the other
    frame_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_one(600 + i, 0);
    for (int i = 0; i < 7; i++) send_one(700 + i, 0);
    chk("t6_pre_valid", 32'(frame_valid), 32'd1);
    chk("t6_pre_lane0", lane_re(0), 32'd600);
    frame_ready = 1'b1;
    send_one(707, 0);
    frame_ready = 1'b0;
    chk("t6_valid", 32'(frame_valid), 32'd1);
    chk_frame("t6_new", 700, 0);
    chk("t6_cnt", 32'(frame_cnt), 32'd2);
    chk("t6_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("t6_cnt_hold", 32'(frame_cnt), 32'd2);
    chk("t6_valid_hold", 32'(frame_valid), 32'd1);
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    chk("t6_cnt_final", 32'(frame_cnt), 32'd3);
    chk("t6_drained", 32'(frame_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
